// File: rtl/data_memory_responder_if.sv
// Data-memory port and TX stream bundle for data_memory_responder.
// The master side is the core MEM stage plus the TX stream consumer.
// The slave side is the responder.
interface data_memory_responder_if;
    logic [31:0] data_memory_addr;
    logic [31:0] data_memory_wd;
    logic        data_memory_we;
    logic [31:0] data_memory_data;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport slave (
        input  data_memory_addr,
        input  data_memory_wd,
        input  data_memory_we,
        input  tx_ready,
        output data_memory_data,
        output tx_data,
        output tx_valid
    );

    modport master (
        output data_memory_addr,
        output data_memory_wd,
        output data_memory_we,
        output tx_ready,
        input  data_memory_data,
        input  tx_data,
        input  tx_valid
    );
endinterface

// File: rtl/data_memory_responder.sv
// Data-memory responder: word-addressed RAM plus a 16-byte MMIO window.
// The MMIO window holds a TX stream FIFO, STATUS, CTRL and an optional cycle counter.
// The optional cycle counter is built only when DATA_MEM_CYCLE_COUNTER_EN is defined.
// Read data is combinational so the core's MEM stage samples it in the same cycle.
module data_memory_responder #(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] IO_BASE    = 32'hFFFF_0000
) (
    input logic                    clk,
    input logic                    reset,
    data_memory_responder_if.slave bus
);

    localparam int unsigned RamIdxW  = $clog2(RAM_WORDS);
    localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW     = PtrW + 1;
    localparam logic [32:0] RamBytes = 33'(RAM_WORDS) * 33'd4;
    localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);

    localparam logic [1:0] RegTxData = 2'd0;
    localparam logic [1:0] RegStatus = 2'd1;
    localparam logic [1:0] RegCtrl   = 2'd2;
    localparam logic [1:0] RegCycles = 2'd3;

    // Storage arrays; neither is reset.
    logic [31:0] ram_mem  [RAM_WORDS];
    logic [31:0] fifo_mem [FIFO_DEPTH];

    // FIFO state
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;

    // Decode
    logic [31:0]        addr;
    logic [31:0]        wd;
    logic               we;
    logic               ram_sel;
    logic               io_sel;
    logic [1:0]         io_reg;
    logic [RamIdxW-1:0] ram_idx;
    logic               unused_addr_bits;

    assign addr             = bus.data_memory_addr;
    assign wd               = bus.data_memory_wd;
    assign we               = bus.data_memory_we;
    assign ram_sel          = {1'b0, addr} < RamBytes;
    assign io_sel           = addr[31:4] == IO_BASE[31:4];
    assign io_reg           = addr[3:2];
    assign ram_idx          = addr[RamIdxW+1:2];
    assign unused_addr_bits = ^addr[1:0];

    // Write strobes per target
    logic ram_we;
    logic push_req;
    logic ctrl_wr;
    logic cyc_wr;
    logic flush;
    logic clr_ovf;

    assign ram_we   = we && ram_sel;
    assign push_req = we && io_sel && (io_reg == RegTxData);
    assign ctrl_wr  = we && io_sel && (io_reg == RegCtrl);
    assign cyc_wr   = we && io_sel && (io_reg == RegCycles);
    assign flush    = ctrl_wr && wd[0];
    assign clr_ovf  = ctrl_wr && wd[1];

    // FIFO handshake
    logic full;
    logic empty;
    logic pop;
    logic push_ok;
    logic push_drop;

    assign full      = count_q == FullCount;
    assign empty     = count_q == '0;
    assign pop       = !empty && bus.tx_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok   = push_req && (!full || pop);
    assign push_drop = push_req && full && !pop;

    assign bus.tx_valid = !empty;
    assign bus.tx_data  = fifo_mem[rd_ptr_q];

    // FIFO pointer, count and overflow next state; flush overrides push/pop.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push_ok) - CntW'(pop);
        end

        if (clr_ovf) begin
            overflow_d = 1'b0;
        end
        if (push_drop) begin
            overflow_d = 1'b1;
        end
    end

    // FIFO control registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO payload storage; written only when a push is accepted.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            fifo_mem[wr_ptr_q] <= wd;
        end
    end

    // Data RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_idx] <= wd;
        end
    end

    logic [31:0] cycles_rd;

`ifdef DATA_MEM_CYCLE_COUNTER_EN
    logic [31:0] cycles_q, cycles_d;

    // Free-running counter; a store loads it instead of incrementing.
    always_comb begin
        cycles_d = cycles_q + 32'd1;
        if (cyc_wr) begin
            cycles_d = wd;
        end
    end

    // Cycle counter register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign cycles_rd = cycles_q;
`else
    logic unused_cyc_wr;

    assign unused_cyc_wr = cyc_wr;
    assign cycles_rd     = '0;
`endif

    // STATUS layout: [0] full, [1] empty, [2] overflow, [15:8] count.
    logic [31:0] status;
    logic [7:0]  count8;

    assign count8 = 8'(count_q);
    assign status = {16'h0000, count8, 5'b00000, overflow_q, empty, full};

    // Combinational read mux; unmapped and write-only registers read as zero.
    always_comb begin
        bus.data_memory_data = '0;
        if (ram_sel) begin
            bus.data_memory_data = ram_mem[ram_idx];
        end else if (io_sel) begin
            case (io_reg)
                RegStatus: bus.data_memory_data = status;
                RegCycles: bus.data_memory_data = cycles_rd;
                default:   bus.data_memory_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: stimulus queues expected read
// values and TX words; a negedge monitor pops and compares them.
module tb_data_memory_responder;

    localparam logic [31:0] Io = 32'hFFFF_0000;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    data_memory_responder_if bus_if ();

    data_memory_responder dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if.slave)
    );

    typedef struct {
        bit          is_valid;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t        chk_q[$];
    logic [31:0] tx_q[$];
    logic        chk_req;
    chk_t        mon_c;
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic report(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares queued read checks and every accepted TX beat.
    always @(negedge clk) begin
        if (chk_req) begin
            if (chk_q.size() == 0) begin
                n_total++;
                $display("FAIL chk_queue_empty at %0t", $time);
            end else begin
                mon_c = chk_q.pop_front();
                if (mon_c.is_valid) begin
                    report(mon_c.name, {31'b0, bus_if.tx_valid}, mon_c.exp);
                end else begin
                    report(mon_c.name, bus_if.data_memory_data, mon_c.exp);
                end
            end
        end
        if (bus_if.tx_valid === 1'b1 && bus_if.tx_ready === 1'b1) begin
            if (tx_q.size() == 0) begin
                n_total++;
                $display("FAIL tx_unexpected: got %h expected no beat at %0t",
                         bus_if.tx_data, $time);
            end else begin
                report("tx_data", bus_if.tx_data, tx_q.pop_front());
            end
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus_if.data_memory_addr = a;
        bus_if.data_memory_wd   = d;
        bus_if.data_memory_we   = 1'b1;
        @(posedge clk);
        #1;
        bus_if.data_memory_we   = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] d, input bit expect_out);
        if (expect_out) tx_q.push_back(d);
        store(Io, d);
    endtask

    task automatic check_rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        bus_if.data_memory_addr = a;
        bus_if.data_memory_we   = 1'b0;
        chk_q.push_back('{1'b0, exp, name});
        chk_req = 1'b1;
        @(posedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    task automatic check_valid(input bit v, input string name);
        bus_if.data_memory_we = 1'b0;
        chk_q.push_back('{1'b1, {31'b0, v}, name});
        chk_req = 1'b1;
        @(posedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                   = 1'b1;
        chk_req                 = 1'b0;
        bus_if.data_memory_addr = '0;
        bus_if.data_memory_wd   = '0;
        bus_if.data_memory_we   = 1'b0;
        bus_if.tx_ready         = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        check_rd(Io + 32'h4, 32'h0000_0002, "status_in_reset");
        check_valid(1'b0, "tx_valid_in_reset");
        reset = 1'b0;
        check_rd(Io + 32'h4, 32'h0000_0002, "status_after_reset");

        // RAM
        store(32'h10, 32'hDEAD_BEEF);
        check_rd(32'h10, 32'hDEAD_BEEF, "ram_load");
        check_rd(32'h13, 32'hDEAD_BEEF, "ram_load_unaligned");
        store(32'h14, 32'h1234_5678);
        check_rd(32'h14, 32'h1234_5678, "ram_load_next_word");
        check_rd(32'h10, 32'hDEAD_BEEF, "ram_neighbour_kept");
        store(32'hFFC, 32'hCAFE_0001);
        check_rd(32'hFFC, 32'hCAFE_0001, "ram_top_word");
        store(32'h0, 32'h1111_1111);
        store(32'h1000, 32'h2222_2222);
        check_rd(32'h1000, 32'h0, "unmapped_past_ram");
        check_rd(32'h0, 32'h1111_1111, "unmapped_no_alias");

        // Fill FIFO, overflow, drain
        for (int i = 1; i <= 8; i++) push_word(32'(i), 1'b1);
        check_rd(Io + 32'h4, 32'h0000_0801, "status_full");
        push_word(32'd9, 1'b0);
        check_rd(Io + 32'h4, 32'h0000_0805, "status_overflow");
        check_rd(Io + 32'h0, 32'h0, "txdata_reads_zero");
        check_rd(Io + 32'h8, 32'h0, "ctrl_reads_zero");
        bus_if.tx_ready = 1'b1;
        cycles(8);
        check_valid(1'b0, "tx_valid_after_drain");
        bus_if.tx_ready = 1'b0;
        check_rd(Io + 32'h4, 32'h0000_0006, "status_drained");
        store(Io + 32'h8, 32'h2);
        check_rd(Io + 32'h4, 32'h0000_0002, "status_ovf_cleared");

        // Push into full FIFO alongside a pop
        for (int i = 1; i <= 8; i++) push_word(32'h100 + 32'(i), 1'b1);
        bus_if.tx_ready = 1'b1;
        push_word(32'hA5, 1'b1);
        bus_if.tx_ready = 1'b0;
        check_rd(Io + 32'h4, 32'h0000_0801, "status_full_push_pop");
        bus_if.tx_ready = 1'b1;
        cycles(8);
        bus_if.tx_ready = 1'b0;
        check_rd(Io + 32'h4, 32'h0000_0002, "status_after_a5");

        // Flush keeps overflow unless bit 1 is set
        for (int i = 1; i <= 9; i++) push_word(32'h300 + 32'(i), 1'b0);
        store(Io + 32'h8, 32'h1);
        check_rd(Io + 32'h4, 32'h0000_0006, "flush_keeps_ovf");
        store(Io + 32'h8, 32'h2);
        check_rd(Io + 32'h4, 32'h0000_0002, "ovf_clear_only");
        for (int i = 1; i <= 3; i++) push_word(32'h400 + 32'(i), 1'b0);
        store(Io + 32'h8, 32'h3);
        check_valid(1'b0, "tx_valid_after_flush");
        check_rd(Io + 32'h4, 32'h0000_0002, "status_after_flush");
        push_word(32'h77, 1'b1);
        check_valid(1'b1, "tx_valid_after_push");
        bus_if.tx_ready = 1'b1;
        cycles(1);
        bus_if.tx_ready = 1'b0;
        check_valid(1'b0, "tx_valid_single_pop");

        // Reset mid-drain with five words left
        for (int i = 1; i <= 6; i++) push_word(32'h200 + 32'(i), 1'b1);
        bus_if.tx_ready = 1'b1;
        cycles(1);
        reset = 1'b1;
        tx_q.delete();
        check_valid(1'b0, "tx_valid_mid_reset");
        check_rd(Io + 32'h4, 32'h0000_0002, "status_mid_reset");
        reset = 1'b0;
        bus_if.tx_ready = 1'b0;
        check_rd(32'h10, 32'hDEAD_BEEF, "ram_kept_over_reset");

        // Cycle counter
`ifdef DATA_MEM_CYCLE_COUNTER_EN
        store(Io + 32'hC, 32'hFFFF_FFFE);
        check_rd(Io + 32'hC, 32'hFFFF_FFFE, "cycles_loaded");
        check_rd(Io + 32'hC, 32'hFFFF_FFFF, "cycles_inc");
        check_rd(Io + 32'hC, 32'h0000_0000, "cycles_wrap");
`else
        check_rd(Io + 32'hC, 32'h0, "cycles_absent");
        store(Io + 32'hC, 32'hFFFF_FFFE);
        check_rd(Io + 32'hC, 32'h0, "cycles_write_ignored");
`endif
        check_rd(32'h8000_0000, 32'h0, "unmapped_read");

        cycles(2);
        report("tx_drained", 32'(tx_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
